// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode/funct constants, loader state enum and instruction legality helper
package mips_pkg;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] J     = 6'b000010;

  localparam logic [5:0] ADD   = 6'b100000;
  localparam logic [5:0] SUB   = 6'b100010;
  localparam logic [5:0] AND   = 6'b100100;
  localparam logic [5:0] OR    = 6'b100101;
  localparam logic [5:0] SLT   = 6'b101010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_BYTES,
    S_WRITE,
    S_DONE,
    S_ERR
  } loader_state_t;

  // True for the instruction subset the single-cycle core decodes.
  function automatic logic is_legal_instr(input logic [31:0] instr);
    logic [5:0] op;
    logic [5:0] fn;
    op = instr[31:26];
    fn = instr[5:0];
    case (op)
      RTYPE:         return (fn inside {ADD, SUB, AND, OR, SLT});
      LW, SW, BEQ, J: return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - big-endian byte-to-word shifter, word_full on the 4th accepted byte
module imem_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  in_data,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [31:0] word;
  logic [1:0]  idx;

  // The byte being accepted lands in [7:0]; earlier bytes move toward [31:24].
  assign word_next = {word[23:0], in_data};
  assign word_full = shift && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word <= '0;
      idx  <= '0;
    end else if (shift) begin
      word <= word_next;
      idx  <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader writing 32-bit words into instruction memory
// Optional opcode screening before each write: IMEM_LOADER_OPCODE_CHECK_EN
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [8:0] DEPTH = 9'(1 << ADDR_W);

  loader_state_t state;
  logic [7:0]    n_words;
  logic          shift;
  logic          word_full;
  logic          word_ok;
  logic [31:0]   word_next;
  logic [8:0]    wl_inc;

  assign shift  = (state == S_BYTES) && in_valid && in_ready;
  assign wl_inc = 9'(words_loaded) + 9'd1;

`ifdef IMEM_LOADER_OPCODE_CHECK_EN
  assign word_ok = is_legal_instr(word_next);
`else
  assign word_ok = 1'b1;
`endif

  imem_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == S_HDR),
    .shift     (shift),
    .in_data   (in_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      n_words      <= '0;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_HDR;
            in_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            imem_addr    <= '0;
          end
        end
        S_HDR: begin
          if (in_valid) begin
            n_words <= in_data;
            if (in_data == 8'd0) begin
              state    <= S_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else if ({1'b0, in_data} > DEPTH) begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= S_BYTES;
            end
          end
        end
        S_BYTES: begin
          if (word_full) begin
            state      <= S_WRITE;
            in_ready   <= 1'b0;
            imem_we    <= word_ok;
            imem_wdata <= word_next;
          end
        end
        S_WRITE: begin
          // A suppressed strobe here means the word failed screening.
          if (!imem_we) begin
            state <= S_ERR;
            error <= 1'b1;
          end else begin
            imem_addr    <= imem_addr + ADDR_W'(1);
            words_loaded <= words_loaded + (ADDR_W+1)'(1);
            if (wl_inc == {1'b0, n_words}) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= S_BYTES;
              in_ready <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader (ADDR_W=6 and ADDR_W=2 instances)
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start2;
  logic [7:0]  in_data;
  logic        in_valid;

  logic        in_ready, imem_we, cpu_hold, done, error;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0]  words_loaded;

  logic        in_ready2, imem_we2, cpu_hold2, done2, error2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic [2:0]  words_loaded2;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [64];
  int          we_count = 0;
  int          we2_count = 0;
  int          ready_viol = 0;
  logic [5:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  int          wc;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  imem_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .cpu_hold(cpu_hold2), .done(done2), .error(error2), .words_loaded(words_loaded2)
  );

  // Instruction memory model and write log
  always @(posedge clk) begin
    if (imem_we) begin
      mem[imem_addr] <= imem_wdata;
      we_count       <= we_count + 1;
      last_addr      <= imem_addr;
      last_data      <= imem_wdata;
      if (in_ready) ready_viol <= ready_viol + 1;
    end
    if (imem_we2) we2_count <= we2_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [7:0] b);
    int cnt;
    cnt      = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (((sel ? in_ready2 : in_ready) !== 1'b1) && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("hs_timeout", 32'(cnt < 40), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) begin
      send(sel, w[i*8 +: 8]);
      if (gap) tick(1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},     32'(in_ready),     32'd0);
    check({tag, "_imem_we"},      32'(imem_we),      32'd0);
    check({tag, "_imem_addr"},    32'(imem_addr),    32'd0);
    check({tag, "_imem_wdata"},   imem_wdata,        32'd0);
    check({tag, "_cpu_hold"},     32'(cpu_hold),     32'd1);
    check({tag, "_done"},         32'(done),         32'd0);
    check({tag, "_error"},        32'(error),        32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    tick(2);
    check_reset_vals("rst");
    reset = 1'b0;
    tick(1);

    // Two-word load
    pulse_start(0);
    send(0, 8'h02);
    send_word(0, 32'h8C010004, 1'b0);
    send_word(0, 32'h00221820, 1'b0);
    tick(2);
    check("load_mem0",     mem[0],                32'h8C010004);
    check("load_mem1",     mem[1],                32'h00221820);
    check("load_we_count", 32'(we_count),         32'd2);
    check("load_done",     32'(done),             32'd1);
    check("load_hold",     32'(cpu_hold),         32'd0);
    check("load_words",    32'(words_loaded),     32'd2);
    check("load_addr",     32'(imem_addr),        32'd2);
    check("load_error",    32'(error),            32'd0);

    // Empty load
    wc = we_count;
    pulse_start(0);
    check("hdr_done_clr",  32'(done),             32'd0);
    check("hdr_hold",      32'(cpu_hold),         32'd1);
    check("hdr_ready",     32'(in_ready),         32'd1);
    send(0, 8'h00);
    check("empty_done",    32'(done),             32'd1);
    check("empty_hold",    32'(cpu_hold),         32'd0);
    check("empty_no_we",   32'(we_count),         32'(wc));
    check("empty_words",   32'(words_loaded),     32'd0);

    // Gapped stream
    wc = we_count;
    pulse_start(0);
    send(0, 8'h02);
    tick(1);
    send_word(0, 32'h8C010004, 1'b1);
    check("gap_first_addr", 32'(last_addr),       32'd0);
    check("gap_first_data", last_data,            32'h8C010004);
    send_word(0, 32'h00221820, 1'b1);
    tick(2);
    check("gap_we_count",  32'(we_count),         32'(wc + 2));
    check("gap_last_addr", 32'(last_addr),        32'd1);
    check("gap_last_data", last_data,             32'h00221820);
    check("gap_ready_we",  32'(ready_viol),       32'd0);
    check("gap_done",      32'(done),             32'd1);

    // Reset after the 6th byte
    wc = we_count;
    pulse_start(0);
    send(0, 8'h02);
    send(0, 8'h8C); send(0, 8'h01); send(0, 8'h00); send(0, 8'h04); send(0, 8'h00);
    reset = 1'b1;
    tick(1);
    check_reset_vals("midrst");
    reset = 1'b0;
    check("midrst_mem0",   mem[0],                32'h8C010004);
    check("midrst_we",     32'(we_count),         32'(wc + 1));

    // start with in_valid in IDLE: header byte must not be consumed early
    in_data = 8'h02; in_valid = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("sv_ready",      32'(in_ready),         32'd1);
    tick(1);
    in_valid = 1'b0;
    send_word(0, 32'h8C010004, 1'b0);
    send_word(0, 32'h00221820, 1'b0);
    tick(2);
    check("reload_mem0",   mem[0],                32'h8C010004);
    check("reload_mem1",   mem[1],                32'h00221820);
    check("reload_we",     32'(we_count),         32'(wc + 3));
    check("reload_words",  32'(words_loaded),     32'd2);
    check("reload_done",   32'(done),             32'd1);

    // Overflow on a 4-word instance
    pulse_start(1);
    send(1, 8'h05);
    tick(1);
    check("ovf_error",     32'(error2),           32'd1);
    check("ovf_hold",      32'(cpu_hold2),        32'd1);
    check("ovf_done",      32'(done2),            32'd0);
    check("ovf_no_we",     32'(we2_count),        32'd0);
    check("ovf_ready",     32'(in_ready2),        32'd0);
    pulse_start(1);
    check("ovf_err_clr",   32'(error2),           32'd0);
    send(1, 8'h01);
    send_word(1, 32'h8C010004, 1'b0);
    tick(2);
    check("ovf2_done",     32'(done2),            32'd1);
    check("ovf2_error",    32'(error2),           32'd0);
    check("ovf2_we",       32'(we2_count),        32'd1);
    check("ovf2_words",    32'(words_loaded2),    32'd1);
    check("ovf2_hold",     32'(cpu_hold2),        32'd0);

    // Illegal opcode word
    wc = we_count;
    pulse_start(0);
    send(0, 8'h02);
    send_word(0, 32'hFC000000, 1'b0);
    tick(2);
`ifdef IMEM_LOADER_OPCODE_CHECK_EN
    check("opc_error",     32'(error),            32'd1);
    check("opc_no_we",     32'(we_count),         32'(wc));
    check("opc_words",     32'(words_loaded),     32'd0);
    check("opc_hold",      32'(cpu_hold),         32'd1);
    check("opc_done",      32'(done),             32'd0);
`else
    check("opc_mem0",      mem[0],                32'hFC000000);
    check("opc_we",        32'(we_count),         32'(wc + 1));
    check("opc_words",     32'(words_loaded),     32'd1);
    check("opc_error",     32'(error),            32'd0);
    send_word(0, 32'h00221820, 1'b0);
    tick(2);
    check("opc_done",      32'(done),             32'd1);
    check("opc_mem1",      mem[1],                32'h00221820);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
